// File: rtl/preg_freelist.sv
// Physical-register free list: 2 allocs + 2 frees per cycle, one-cycle redirect restore.
// Latency: grants are combinational from registered state; frees become allocatable next cycle.
// Backpressure: alloc_ready drops below 2 free entries, and requests are then dropped. FREELIST_CHECK_EN enables fl_error.
module preg_freelist #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32,
  parameter int FL_DEPTH = PREG_NUM - LREG_NUM,
  parameter int PREG_W   = 6,
  parameter int FL_W     = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc0_req,
  input  logic              alloc1_req,
  output logic              alloc_ready,
  output logic [PREG_W-1:0] alloc0_preg,
  output logic [PREG_W-1:0] alloc1_preg,
  input  logic              commit0_valid,
  input  logic              commit0_need_to_wb,
  input  logic [PREG_W-1:0] commit0_old_prd,
  input  logic              commit1_valid,
  input  logic              commit1_need_to_wb,
  input  logic [PREG_W-1:0] commit1_old_prd,
  input  logic              redirect_valid,
  output logic [FL_W:0]     free_count,
  output logic              fl_error
);

  localparam logic [FL_W:0] CNT_TWO = (FL_W+1)'(2);

  logic [PREG_W-1:0] mem_q [FL_DEPTH];
  logic [PREG_W-1:0] mem_d [FL_DEPTH];
  logic [FL_W:0]     spec_head_q, spec_head_d;
  logic [FL_W:0]     arch_head_q, arch_head_d;
  logic [FL_W:0]     tail_q, tail_d;
  logic [FL_W:0]     free_cnt, n_alloc, n_free;
  logic [FL_W-1:0]   rd_idx1, wr_idx1;
  logic              free0, free1;

  always_comb begin
    free_cnt    = tail_q - spec_head_q;
    alloc_ready = (free_cnt >= CNT_TWO);
    // Slot 1 reads the head entry when slot 0 is idle.
    rd_idx1     = spec_head_q[FL_W-1:0] + FL_W'(alloc0_req);
    alloc0_preg = mem_q[spec_head_q[FL_W-1:0]];
    alloc1_preg = mem_q[rd_idx1];
    free_count  = free_cnt;

    free0   = commit0_valid & commit0_need_to_wb;
    free1   = commit1_valid & commit1_need_to_wb;
    n_free  = (FL_W+1)'(free0) + (FL_W+1)'(free1);
    n_alloc = (FL_W+1)'(alloc0_req) + (FL_W+1)'(alloc1_req);
    wr_idx1 = tail_q[FL_W-1:0] + FL_W'(free0);

    mem_d = mem_q;
    if (free0) mem_d[tail_q[FL_W-1:0]] = commit0_old_prd;
    if (free1) mem_d[wr_idx1] = commit1_old_prd;

    tail_d      = tail_q + n_free;
    arch_head_d = arch_head_q + n_free;

    spec_head_d = spec_head_q;
    // Redirect rewinds to the committed point including this cycle's commits.
    if (redirect_valid) spec_head_d = arch_head_d;
    else if (alloc_ready) spec_head_d = spec_head_q + n_alloc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= PREG_W'(LREG_NUM + i);
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= {1'b1, {FL_W{1'b0}}};
    end else begin
      mem_q       <= mem_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic            fl_error_q, fl_error_d;
  logic            err_alloc, err_over, err_pass;
  logic [FL_W+1:0] fill;
  logic [FL_W:0]   pass_dist;

  always_comb begin
    err_alloc = (alloc0_req | alloc1_req) & ~alloc_ready;
    fill      = {1'b0, free_cnt} + {1'b0, n_free};
    err_over  = (fill > (FL_W+2)'(FL_DEPTH));
    // Normally arch trails spec, so arch - spec is zero or has its wrap bit set.
    pass_dist = arch_head_d - spec_head_d;
    err_pass  = (pass_dist != '0) && !pass_dist[FL_W];
    fl_error_d = fl_error_q | err_alloc | err_over | err_pass;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fl_error_q <= 1'b0;
    else          fl_error_q <= fl_error_d;
  end

  assign fl_error = fl_error_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n && err_alloc) $error("preg_freelist: alloc request while not ready");
    if (reset_n && err_over)  $error("preg_freelist: free overflows the list");
    if (reset_n && err_pass)  $error("preg_freelist: arch_head passed spec_head");
  end
`endif
`else
  assign fl_error = 1'b0;
`endif

endmodule
